// File: rtl/attention_score_mask_rowmax.sv
// Score mask / row-max stage: walks the scaled-score buffer, masks, sanitises NaN.
// Optional causal masking is compiled in with `define ATT_CAUSAL_MASK_EN.
module attention_score_mask_rowmax #(
    parameter int T      = 4,
    parameter int DATA_W = 32,
    parameter int T_W    = (T <= 1) ? 1 : $clog2(T)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       kv_len,
    output logic              busy,
    output logic              done,
    output logic              sc_re,
    output logic [T_W-1:0]    sc_tq,
    output logic [T_W-1:0]    sc_tk,
    input  logic [DATA_W-1:0] sc_rdata,
    input  logic              sc_rvalid,
    input  logic              ms_re,
    input  logic [T_W-1:0]    ms_tq,
    input  logic [T_W-1:0]    ms_tk,
    output logic [DATA_W-1:0] ms_rdata,
    output logic              ms_rvalid,
    input  logic              mx_re,
    input  logic [T_W-1:0]    mx_tq,
    output logic [DATA_W-1:0] mx_rdata,
    output logic              mx_rvalid,
    output logic              nan_seen
);

    localparam logic [DATA_W-1:0] NEG_INF = DATA_W'(32'hFF800000);
    localparam logic [DATA_W-1:0] SIGN    = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t            state_q;
    logic              busy_q, done_q, sc_re_q, nan_q;
    logic [T_W-1:0]    tq_q, tk_q;
    logic [15:0]       kvl_q;
    logic [DATA_W-1:0] run_max_q;
    logic [DATA_W-1:0] ms_q [T][T];
    logic [DATA_W-1:0] mx_q [T];
    logic              ms_rvalid_q, mx_rvalid_q;
    logic [DATA_W-1:0] ms_rdata_q, mx_rdata_q;

    logic [15:0]       kvl_d;
    logic              masked, rd_nan, step, row_end, last;
    logic [DATA_W-1:0] rd_val, elem_d, max_d;

    // Ordering key: unsigned compare of keys matches FP32 order, -0 below +0
    function automatic logic [DATA_W-1:0] fkey(input logic [DATA_W-1:0] b);
        return b[DATA_W-1] ? ~b : (b | SIGN);
    endfunction

    // Mask decision, NaN sanitising and running-max candidate
    always_comb begin
        kvl_d   = (kv_len > 16'(T)) ? 16'(T) : kv_len;
        masked  = (16'(tk_q) >= kvl_q);
`ifdef ATT_CAUSAL_MASK_EN
        masked  = masked || (tk_q > tq_q);
`endif
        rd_nan  = (sc_rdata[30:23] == 8'hFF) && (sc_rdata[22:0] != 23'd0);
        rd_val  = rd_nan ? NEG_INF : sc_rdata;
        step    = ((state_q == S_ISSUE) && masked) ||
                  ((state_q == S_WAIT) && sc_rvalid && !sc_re_q);
        elem_d  = (state_q == S_WAIT) ? rd_val : NEG_INF;
        max_d   = run_max_q;
        if ((state_q == S_WAIT) && (fkey(rd_val) > fkey(run_max_q)))
            max_d = rd_val;
        row_end = (tk_q == T_W'(T - 1));
        last    = row_end && (tq_q == T_W'(T - 1));
    end

    // Pass sequencer: element walk, upstream requests, array and row-max writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sc_re_q   <= 1'b0;
            nan_q     <= 1'b0;
            tq_q      <= '0;
            tk_q      <= '0;
            kvl_q     <= '0;
            run_max_q <= NEG_INF;
            for (int i = 0; i < T; i++) begin
                mx_q[i] <= NEG_INF;
                for (int j = 0; j < T; j++)
                    ms_q[i][j] <= NEG_INF;
            end
        end else begin
            done_q  <= 1'b0;
            sc_re_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        kvl_q     <= kvl_d;
                        nan_q     <= 1'b0;
                        tq_q      <= '0;
                        tk_q      <= '0;
                        run_max_q <= NEG_INF;
                        busy_q    <= 1'b1;
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!masked) begin
                        sc_re_q <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (step && rd_nan)
                        nan_q <= 1'b1;
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
            if (step) begin
                ms_q[tq_q][tk_q] <= elem_d;
                if (row_end) begin
                    mx_q[tq_q] <= max_d;
                    run_max_q  <= NEG_INF;
                    tk_q       <= '0;
                    tq_q       <= tq_q + 1'b1;
                end else begin
                    run_max_q  <= max_d;
                    tk_q       <= tk_q + 1'b1;
                end
                state_q <= last ? S_DONE : S_ISSUE;
            end
        end
    end

    // Downstream read ports, one-cycle latency, blocked during a pass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_rvalid_q <= 1'b0;
            mx_rvalid_q <= 1'b0;
            ms_rdata_q  <= '0;
            mx_rdata_q  <= '0;
        end else begin
            ms_rvalid_q <= ms_re && !busy_q;
            mx_rvalid_q <= mx_re && !busy_q;
            if (ms_re && !busy_q)
                ms_rdata_q <= ms_q[ms_tq][ms_tk];
            if (mx_re && !busy_q)
                mx_rdata_q <= mx_q[mx_tq];
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sc_re     = sc_re_q;
    assign sc_tq     = tq_q;
    assign sc_tk     = tk_q;
    assign nan_seen  = nan_q;
    assign ms_rdata  = ms_rdata_q;
    assign ms_rvalid = ms_rvalid_q;
    assign mx_rdata  = mx_rdata_q;
    assign mx_rvalid = mx_rvalid_q;

endmodule

// File: tb/tb_attention_score_mask_rowmax.sv
// Bench for attention_score_mask_rowmax: upstream responder, scoreboard readback.
// Honours ATT_CAUSAL_MASK_EN in its reference model.
module tb_attention_score_mask_rowmax;

    localparam int T = 4;
    localparam logic [31:0] NINF = 32'hFF800000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] kv_len = '0;
    logic        busy, done, sc_re;
    logic [1:0]  sc_tq, sc_tk;
    logic [31:0] sc_rdata = '0;
    logic        sc_rvalid = 1'b0;
    logic        ms_re = 1'b0;
    logic [1:0]  ms_tq = '0, ms_tk = '0;
    logic [31:0] ms_rdata;
    logic        ms_rvalid;
    logic        mx_re = 1'b0;
    logic [1:0]  mx_tq = '0;
    logic [31:0] mx_rdata;
    logic        mx_rvalid;
    logic        nan_seen;

    attention_score_mask_rowmax #(.T(T), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .kv_len(kv_len),
        .busy(busy), .done(done),
        .sc_re(sc_re), .sc_tq(sc_tq), .sc_tk(sc_tk),
        .sc_rdata(sc_rdata), .sc_rvalid(sc_rvalid),
        .ms_re(ms_re), .ms_tq(ms_tq), .ms_tk(ms_tk),
        .ms_rdata(ms_rdata), .ms_rvalid(ms_rvalid),
        .mx_re(mx_re), .mx_tq(mx_tq),
        .mx_rdata(mx_rdata), .mx_rvalid(mx_rvalid),
        .nan_seen(nan_seen)
    );

    always #5 clk = ~clk;

    logic [31:0] mem    [T][T];
    logic [31:0] exp_ms [T][T];
    logic [31:0] exp_mx [T];
    int          exp_reads;
    logic        exp_nan;
    int          lat = 1;
    int          pend = 0;
    logic [1:0]  pq = '0, pk = '0;
    int          sc_re_cnt = 0;
    int          done_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    int          cyc;
    logic [31:0] ms_exp_q [$];
    logic [31:0] mx_exp_q [$];

    // Upstream score buffer with programmable latency; also counts pulses
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 0;
                sc_rvalid = 1'b0;
            end else begin
                sc_rvalid = 1'b0;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        sc_rvalid = 1'b1;
                        sc_rdata = mem[pq][pk];
                    end
                end
                if (sc_re) begin
                    pend = lat;
                    pq = sc_tq;
                    pk = sc_tk;
                    sc_re_cnt++;
                end
                if (done)
                    done_cnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic bit is_masked(input int q, input int k, input int kvl);
`ifdef ATT_CAUSAL_MASK_EN
        if (k > q)
            return 1'b1;
`endif
        return k >= kvl;
    endfunction

    // Float greater-than on bit patterns; -0 treated as below +0
    function automatic bit fgt(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31])
            return !a[31];
        if (!a[31])
            return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    task automatic build_model(input int kv);
        int kvl;
        logic [31:0] v, m;
        kvl = (kv > T) ? T : kv;
        exp_reads = 0;
        exp_nan = 1'b0;
        for (int q = 0; q < T; q++) begin
            m = NINF;
            for (int k = 0; k < T; k++) begin
                if (is_masked(q, k, kvl)) begin
                    exp_ms[q][k] = NINF;
                end else begin
                    exp_reads++;
                    v = mem[q][k];
                    if (v[30:23] == 8'hFF && v[22:0] != 0) begin
                        v = NINF;
                        exp_nan = 1'b1;
                    end
                    exp_ms[q][k] = v;
                    if (fgt(v, m))
                        m = v;
                end
            end
            exp_mx[q] = m;
        end
    endtask

    task automatic model_all_ninf();
        for (int q = 0; q < T; q++) begin
            exp_mx[q] = NINF;
            for (int k = 0; k < T; k++)
                exp_ms[q][k] = NINF;
        end
        exp_nan = 1'b0;
    endtask

    task automatic start_pass(input int kv);
        @(negedge clk);
        kv_len = kv[15:0];
        sc_re_cnt = 0;
        done_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int c);
        c = 0;
        while (!done && c < 1000) begin
            @(negedge clk);
            c++;
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
    endtask

    // Pipelined readback of every element and row max through the scoreboard
    task automatic read_all(input string nm);
        int n;
        n = T * T;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk({nm, "_ms_rvalid"}, 32'(ms_rvalid), 32'd1);
                if (ms_rvalid && ms_exp_q.size() > 0)
                    chk($sformatf("%s_ms[%0d]", nm, i - 1), ms_rdata,
                        ms_exp_q.pop_front());
            end
            if (i > 0 && i <= T) begin
                chk({nm, "_mx_rvalid"}, 32'(mx_rvalid), 32'd1);
                if (mx_rvalid && mx_exp_q.size() > 0)
                    chk($sformatf("%s_mx[%0d]", nm, i - 1), mx_rdata,
                        mx_exp_q.pop_front());
            end
            if (i < n) begin
                ms_re = 1'b1;
                ms_tq = 2'(i / T);
                ms_tk = 2'(i % T);
                ms_exp_q.push_back(exp_ms[i / T][i % T]);
            end else begin
                ms_re = 1'b0;
            end
            if (i < T) begin
                mx_re = 1'b1;
                mx_tq = 2'(i);
                mx_exp_q.push_back(exp_mx[i]);
            end else begin
                mx_re = 1'b0;
            end
        end
    endtask

    task automatic read_mx0(output logic [31:0] v);
        @(negedge clk);
        mx_re = 1'b1;
        mx_tq = 2'd0;
        @(negedge clk);
        mx_re = 1'b0;
        chk("mx0_rvalid", 32'(mx_rvalid), 32'd1);
        v = mx_rdata;
    endtask

    task automatic full_pass(input int kv, input int l, input string nm);
        lat = l;
        build_model(kv);
        start_pass(kv);
        wait_done(cyc);
        repeat (3) @(negedge clk);
        chk({nm, "_sc_re_cnt"}, 32'(sc_re_cnt), 32'(exp_reads));
        chk({nm, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({nm, "_nan_seen"}, 32'(nan_seen), 32'(exp_nan));
        read_all(nm);
    endtask

    logic [31:0] v0;

    initial begin
        mem[0] = '{32'h3f800000, 32'h40000000, 32'hbf000000, 32'h3e800000};
        mem[1] = '{32'hbf800000, 32'hc0000000, 32'hbf000000, 32'hc0400000};
        mem[2] = '{32'h80000000, 32'h00000000, 32'h80000000, 32'h00000000};
        mem[3] = '{32'h41200000, 32'h7f800000, 32'h00000000, 32'hc1200000};

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sc_re", 32'(sc_re), 32'd0);
        chk("rst_nan", 32'(nan_seen), 32'd0);
        chk("rst_ms_rdata", ms_rdata, 32'd0);
        chk("rst_mx_rdata", mx_rdata, 32'd0);
        chk("rst_sc_tq", 32'(sc_tq), 32'd0);
        rst_n = 1'b1;
        model_all_ninf();
        read_all("rst");

        full_pass(4, 1, "kv4");
        read_mx0(v0);
`ifdef ATT_CAUSAL_MASK_EN
        chk("kv4_mx0_lit", v0, 32'h3f800000);
        chk("kv4_reads_lit", 32'(sc_re_cnt), 32'd10);
`else
        chk("kv4_mx0_lit", v0, 32'h40000000);
        chk("kv4_reads_lit", 32'(sc_re_cnt), 32'd16);
`endif

        full_pass(2, 1, "kv2");

        full_pass(0, 1, "kv0");
        chk("kv0_cycles", 32'(cyc), 32'(T * T + 1));

        mem[1][2] = 32'h7fc00000;
        full_pass(100, 3, "nan");

        lat = 2;
        build_model(4);
        start_pass(4);
        repeat (4) @(negedge clk);
        start = 1'b1;
        kv_len = 16'd1;
        ms_re = 1'b1;
        mx_re = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ms_re = 1'b0;
        mx_re = 1'b0;
        chk("busy_ms_rvalid", 32'(ms_rvalid), 32'd0);
        chk("busy_mx_rvalid", 32'(mx_rvalid), 32'd0);
        wait_done(cyc);
        repeat (3) @(negedge clk);
        chk("restart_sc_re_cnt", 32'(sc_re_cnt), 32'(exp_reads));
        chk("restart_done_cnt", 32'(done_cnt), 32'd1);
        read_all("restart");

        lat = 1;
        start_pass(4);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sc_re", 32'(sc_re), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (40) @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt), 32'd0);
        chk("midrst_nan", 32'(nan_seen), 32'd0);
        model_all_ninf();
        read_all("midrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/attention_score_mask_rowmax.md
Name: attention_score_mask_rowmax

Overview:
- Downstream stage of the QK^T+scale score block.
- Walks the T x T scaled-score buffer through that block's read port (sc_re/sc_tq/sc_tk -> sc_rdata/sc_rvalid).
- Applies key-length masking (optionally causal masking), sanitises NaN, and records the FP32 max of each row.
- Holds the masked score matrix and the row-max vector in local registers for the softmax stage to read.

Parameters:
- T, 4, sequence length (rows and columns of the score matrix)
- DATA_W, 32, data width; FP32 only, must be 32
- T_W, (T<=1)?1:$clog2(T), index width (derived)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin a pass (ignored while busy)
- kv_len  in  16  number of valid keys; values above T are clamped to T
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the pass completes
- sc_re  out  1  read request to the upstream score buffer
- sc_tq  out  T_W  upstream read row
- sc_tk  out  T_W  upstream read column
- sc_rdata  in  DATA_W  upstream read data
- sc_rvalid  in  1  upstream read data valid; latency is any value >= 1 cycle
- ms_re  in  1  masked-score read request
- ms_tq  in  T_W  masked-score read row
- ms_tk  in  T_W  masked-score read column
- ms_rdata  out  DATA_W  masked-score read data
- ms_rvalid  out  1  masked-score read valid
- mx_re  in  1  row-max read request
- mx_tq  in  T_W  row-max read row
- mx_rdata  out  DATA_W  row-max read data
- mx_rvalid  out  1  row-max read valid
- nan_seen  out  1  sticky: a NaN was read in the current or last pass

Behaviour:
- Reset (asynchronous, active-low): FSM to IDLE. busy, done, sc_re, ms_rvalid, mx_rvalid, nan_seen = 0. sc_tq, sc_tk, ms_rdata, mx_rdata = 0. Masked-score array and row-max array = 0xFF800000 (-inf). Reset mid-pass abandons the pass; no done pulse.
- Accepted start (IDLE only): latches kvl = min(kv_len, T); clears nan_seen; sets (tq,tk) = (0,0); running max = -inf; goes to ISSUE. start while busy has no effect.
- Mask rule: element (tq,tk) is masked if tk >= kvl. With ATT_CAUSAL_MASK_EN it is also masked if tk > tq.
- ISSUE, element masked:
  - No upstream read.
  - Masked array[tq][tk] = 0xFF800000; running max is unchanged.
  - Advance in the same cycle. One cycle per masked element.
- ISSUE, element unmasked:
  - Drive sc_re = 1 for exactly one cycle with sc_tq/sc_tk = (tq,tk); go to WAIT.
- WAIT:
  - sc_re = 0; hold the address until sc_rvalid is sampled high.
  - In that cycle, value v = sc_rdata. If v is NaN (exp = 0xFF, frac != 0), substitute 0xFF800000 and set nan_seen.
  - Store v into masked array[tq][tk]; update running max; advance.
  - A sc_rvalid seen while not in WAIT is ignored.
- Advance:
  - If tk == T-1: row-max array[tq] = final running max, reset running max to -inf, tk = 0, tq++.
  - After the last element (T-1,T-1) go to DONE.
- DONE: done = 1 for one cycle, busy drops in the same cycle, return to IDLE.
- FP32 max: map bits b to a key: b[31] ? ~b : (b | 0x80000000). Compare keys unsigned. On a tie the existing max is kept. -0 orders below +0.
- A row with every element masked yields max 0xFF800000.
- Downstream reads (ms_re, mx_re): one-cycle latency; rvalid pulses one cycle after re. Accepted only while not busy; while busy, ms_re and mx_re are ignored (no rvalid). The arrays keep their values between passes until the next start overwrites them.
- kv_len = 0: all elements masked; zero upstream reads; every row max = 0xFF800000; done after T*T + 1 cycles.

Optional Feature:
- Macro: ATT_CAUSAL_MASK_EN.
- Defined: elements with tk > tq are also masked and are not read upstream.
- Undefined: only kv_len masking applies; no comparator on tq.

Test Plan:
- Row 0 upstream = {3f800000, 40000000, bf000000, 3e800000}, kv_len=4, causal off -> ms row 0 unchanged; mx[0] = 40000000; exactly 16 sc_re pulses; one done pulse.
- Same data, kv_len=2 -> ms[0] = {3f800000, 40000000, ff800000, ff800000}; mx[0] = 40000000; 8 sc_re pulses total.
- ATT_CAUSAL_MASK_EN defined, kv_len=4 -> ms[0] = {3f800000, ff800000, ff800000, ff800000}; mx[0] = 3f800000; 10 sc_re pulses.
- All-negative row {bf800000, c0000000, bf000000, c0400000} -> mx = bf000000. Row {80000000, 00000000, ...} -> mx = 00000000.
- Upstream returns 7fc00000 at (1,2) with sc_rvalid latency 3 -> ms[1][2] = ff800000; nan_seen = 1; the pass still completes.
- Second start mid-pass is ignored (sc_re count unchanged). rst_n low mid-pass -> busy = 0, no done, arrays = ff800000. ms_re while busy -> no ms_rvalid.
